// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared state encoding and byte width for the FIFO read-side unpacker
package fifo_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        SEND_FIRST  = 2'd1,
        SEND_SECOND = 2'd2,
        SEND_CSUM   = 2'd3
    } unpack_state_t;

endpackage

// File: rtl/fifo_byte_unpacker.sv
// rtl/fifo_byte_unpacker.sv - pops 16-bit FWFT FIFO words, streams them as bytes, closes each frame with an XOR checksum byte
module fifo_byte_unpacker
    import fifo_pkg::*;
#(
    parameter int DSIZE       = 16,
    parameter int FRAME_WORDS = 4,
    parameter bit MSB_FIRST   = 1'b1
) (
    input  logic              rclk,
    input  logic              rrst,
    input  logic [DSIZE-1:0]  rdata,
    input  logic              rempty,
    output logic              r_en,
    output logic [BYTE_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              frame_done
);

    localparam int CW = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(FRAME_WORDS - 1);

    generate
        if (DSIZE != 16) begin : g_bad_dsize
            $error("fifo_byte_unpacker: DSIZE must be 16");
        end
        if (FRAME_WORDS < 1) begin : g_bad_frame
            $error("fifo_byte_unpacker: FRAME_WORDS must be at least 1");
        end
    endgenerate

    unpack_state_t     r_state;
    unpack_state_t     w_next_state;
    logic [15:0]       r_hold;
    logic [BYTE_W-1:0] r_csum;
    logic [CW-1:0]     r_word_cnt;
    logic              r_frame_done;

    logic              w_hs;
    logic              w_last_word;
    logic [BYTE_W-1:0] w_first_byte;
    logic [BYTE_W-1:0] w_second_byte;

    assign w_first_byte  = MSB_FIRST ? r_hold[15:8] : r_hold[7:0];
    assign w_second_byte = MSB_FIRST ? r_hold[7:0]  : r_hold[15:8];
    assign w_last_word   = (r_word_cnt == LAST_CNT);

    assign out_valid  = (r_state != IDLE);
    assign out_last   = (r_state == SEND_CSUM);
    assign frame_done = r_frame_done;
    assign w_hs       = out_valid && out_ready;

    always_comb begin
        out_data = '0;
        case (r_state)
            SEND_FIRST:  out_data = w_first_byte;
            SEND_SECOND: out_data = w_second_byte;
            SEND_CSUM:   out_data = r_csum;
            default:     out_data = '0;
        endcase
    end

    // Pop in IDLE or on the final byte of a word/frame so the next word follows without a bubble.
    always_comb begin
        r_en = 1'b0;
        if (!rrst && !rempty) begin
            case (r_state)
                IDLE:        r_en = 1'b1;
                SEND_SECOND: r_en = out_ready && !w_last_word;
                SEND_CSUM:   r_en = out_ready;
                default:     r_en = 1'b0;
            endcase
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (r_en) w_next_state = SEND_FIRST;
            end
            SEND_FIRST: begin
                if (w_hs) w_next_state = SEND_SECOND;
            end
            SEND_SECOND: begin
                if (w_hs) begin
                    if (w_last_word) w_next_state = SEND_CSUM;
                    else             w_next_state = r_en ? SEND_FIRST : IDLE;
                end
            end
            SEND_CSUM: begin
                if (w_hs) w_next_state = r_en ? SEND_FIRST : IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge rclk) begin
        if (rrst) r_state <= IDLE;
        else      r_state <= w_next_state;
    end

    always_ff @(posedge rclk) begin
        if (rrst) begin
            r_hold       <= '0;
            r_csum       <= '0;
            r_word_cnt   <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            if (r_en) r_hold <= rdata;
            case (r_state)
                SEND_FIRST: begin
                    if (w_hs) r_csum <= r_csum ^ out_data;
                end
                SEND_SECOND: begin
                    if (w_hs) begin
                        r_csum <= r_csum ^ out_data;
                        if (w_last_word) r_word_cnt <= '0;
                        else             r_word_cnt <= r_word_cnt + 1'b1;
                    end
                end
                SEND_CSUM: begin
                    if (w_hs) begin
                        r_csum       <= '0;
                        r_frame_done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_byte_unpacker.sv
// tb/tb_fifo_byte_unpacker.sv - scoreboard bench driving MSB-first and LSB-first unpackers from FWFT source queues
module tb_fifo_byte_unpacker;

    logic        rclk;
    logic        rrst;
    logic        out_ready;
    logic [15:0] rdata     [2];
    logic        rempty    [2];
    logic        r_en      [2];
    logic [7:0]  out_data  [2];
    logic        out_valid [2];
    logic        out_last  [2];
    logic        frame_done[2];

    logic [15:0] src_q [2][$];
    logic [8:0]  exp_q [2][$];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int pops    [2];
    int fd_cnt  [2];
    int hs_cnt  [2];
    int hs_first[2];
    int hs_last [2];
    logic [7:0] model_csum;
    int         model_cnt;

    initial rclk = 1'b0;
    always #5 rclk = ~rclk;
    always @(posedge rclk) cyc <= cyc + 1;

    genvar g;
    generate
        for (g = 0; g < 2; g++) begin : g_dut
            fifo_byte_unpacker #(
                .DSIZE(16), .FRAME_WORDS(2), .MSB_FIRST((g == 0) ? 1'b1 : 1'b0)
            ) u_dut (
                .rclk(rclk), .rrst(rrst), .rdata(rdata[g]), .rempty(rempty[g]),
                .r_en(r_en[g]), .out_data(out_data[g]), .out_valid(out_valid[g]),
                .out_ready(out_ready), .out_last(out_last[g]), .frame_done(frame_done[g])
            );

            // FWFT source: pop on r_en at the edge, present the new head shortly after.
            always @(posedge rclk) begin
                if (r_en[g] && src_q[g].size() > 0) begin
                    void'(src_q[g].pop_front());
                    pops[g] = pops[g] + 1;
                end
                #1;
                rempty[g] = (src_q[g].size() == 0);
                rdata[g]  = (src_q[g].size() > 0) ? src_q[g][0] : 16'h0000;
            end

            logic       prev_stall;
            logic [8:0] prev_beat;
            initial prev_stall = 1'b0;

            always @(negedge rclk) begin
                logic [8:0] exp_b;
                if (r_en[g] && rempty[g]) begin
                    total = total + 1; bad = bad + 1;
                    $display("FAIL underflow dut%0d r_en=1 required 0 while empty", g);
                end
                if (frame_done[g]) fd_cnt[g] = fd_cnt[g] + 1;
                if (!rrst) begin
                    if (prev_stall) begin
                        total = total + 1;
                        if (!out_valid[g] || {out_last[g], out_data[g]} != prev_beat) begin
                            bad = bad + 1;
                            $display("FAIL hold dut%0d got %h required %h", g, {out_last[g], out_data[g]}, prev_beat);
                        end
                    end
                    if (out_valid[g] && out_ready) begin
                        total = total + 1;
                        if (exp_q[g].size() == 0) begin
                            bad = bad + 1;
                            $display("FAIL extra_byte dut%0d got %h required none", g, {out_last[g], out_data[g]});
                        end else begin
                            exp_b = exp_q[g].pop_front();
                            if ({out_last[g], out_data[g]} != exp_b) begin
                                bad = bad + 1;
                                $display("FAIL byte dut%0d got last/data %h required %h", g, {out_last[g], out_data[g]}, exp_b);
                            end
                        end
                        if (hs_cnt[g] == 0) hs_first[g] = cyc;
                        hs_last[g] = cyc;
                        hs_cnt[g]  = hs_cnt[g] + 1;
                    end
                    prev_stall = out_valid[g] && !out_ready;
                    prev_beat  = {out_last[g], out_data[g]};
                end else begin
                    prev_stall = 1'b0;
                end
            end
        end
    endgenerate

    task automatic tick();
        @(posedge rclk);
        #2;
    endtask

    task automatic check(input string name, input int got, input int want);
        total = total + 1;
        if (got != want) begin
            bad = bad + 1;
            $display("FAIL %s got %0d required %0d", name, got, want);
        end
    endtask

    task automatic refresh_src();
        for (int k = 0; k < 2; k++) begin
            rempty[k] = (src_q[k].size() == 0);
            rdata[k]  = (src_q[k].size() > 0) ? src_q[k][0] : 16'h0000;
        end
    endtask

    task automatic put_src(input logic [15:0] w);
        for (int k = 0; k < 2; k++) src_q[k].push_back(w);
        refresh_src();
    endtask

    task automatic put_word(input logic [15:0] w);
        put_src(w);
        exp_q[0].push_back({1'b0, w[15:8]});
        exp_q[0].push_back({1'b0, w[7:0]});
        exp_q[1].push_back({1'b0, w[7:0]});
        exp_q[1].push_back({1'b0, w[15:8]});
        model_csum = model_csum ^ w[15:8] ^ w[7:0];
        model_cnt  = model_cnt + 1;
        if (model_cnt == 2) begin
            for (int k = 0; k < 2; k++) exp_q[k].push_back({1'b1, model_csum});
            model_csum = 8'h00;
            model_cnt  = 0;
        end
    endtask

    task automatic clear_stats();
        for (int k = 0; k < 2; k++) begin
            pops[k] = 0; fd_cnt[k] = 0; hs_cnt[k] = 0; hs_first[k] = 0; hs_last[k] = 0;
        end
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((exp_q[0].size() != 0 || exp_q[1].size() != 0) && n < 200) begin
            tick();
            n++;
        end
        check({name, "_drain_timeout"}, (n < 200) ? 1 : 0, 1);
        tick(); tick();
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            rdata[k] = 16'h0000; rempty[k] = 1'b1;
        end
        rrst = 1'b1; out_ready = 1'b1;
        model_csum = 8'h00; model_cnt = 0;
        clear_stats();
        tick(); tick();
        for (int k = 0; k < 2; k++) begin
            check($sformatf("rst_valid%0d", k), int'(out_valid[k]), 0);
            check($sformatf("rst_data%0d", k), int'(out_data[k]), 0);
            check($sformatf("rst_last%0d", k), int'(out_last[k]), 0);
            check($sformatf("rst_ren%0d", k), int'(r_en[k]), 0);
            check($sformatf("rst_fd%0d", k), int'(frame_done[k]), 0);
        end
        rrst = 1'b0;
        tick();

        // Basic frame: 12 34 AB CD 40 (LSB-first: 34 12 CD AB 40)
        clear_stats();
        put_word(16'h1234); put_word(16'hABCD);
        drain("basic");
        for (int k = 0; k < 2; k++) begin
            check($sformatf("basic_pops%0d", k), pops[k], 2);
            check($sformatf("basic_fd%0d", k), fd_cnt[k], 1);
            check($sformatf("basic_span%0d", k), hs_last[k] - hs_first[k], 4);
        end

        // Backpressure on the second byte of the first word
        clear_stats();
        out_ready = 1'b0;
        put_word(16'h1234); put_word(16'hABCD);
        tick(); tick();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        tick(); tick(); tick();
        check("bp_data0", int'(out_data[0]), 'h34);
        check("bp_data1", int'(out_data[1]), 'h12);
        check("bp_pops0", pops[0], 1);
        out_ready = 1'b1;
        drain("bp");
        check("bp_pops_end0", pops[0], 2);
        check("bp_fd0", fd_cnt[0], 1);

        // Source runs empty mid-frame
        clear_stats();
        put_word(16'h1234);
        for (int i = 0; i < 8; i++) tick();
        check("stall_valid0", int'(out_valid[0]), 0);
        check("stall_valid1", int'(out_valid[1]), 0);
        put_word(16'hABCD);
        drain("stall");
        check("stall_fd0", fd_cnt[0], 1);

        // Preloaded stream: 10 bytes back to back, checksums 40 and FF
        clear_stats();
        out_ready = 1'b0;
        put_word(16'h1234); put_word(16'hABCD); put_word(16'h0F0F); put_word(16'h00FF);
        tick(); tick();
        out_ready = 1'b1;
        drain("stream");
        for (int k = 0; k < 2; k++) begin
            check($sformatf("stream_pops%0d", k), pops[k], 4);
            check($sformatf("stream_fd%0d", k), fd_cnt[k], 2);
            check($sformatf("stream_hs%0d", k), hs_cnt[k], 10);
            check($sformatf("stream_span%0d", k), hs_last[k] - hs_first[k], 9);
        end

        // Reset right after the first byte handshakes
        clear_stats();
        put_src(16'h1234);
        exp_q[0].push_back({1'b0, 8'h12});
        exp_q[1].push_back({1'b0, 8'h34});
        tick(); tick();
        rrst = 1'b1;
        tick();
        rrst = 1'b0;
        check("rst_mid_valid0", int'(out_valid[0]), 0);
        check("rst_mid_valid1", int'(out_valid[1]), 0);
        check("rst_mid_q0", exp_q[0].size(), 0);
        model_csum = 8'h00; model_cnt = 0;
        put_word(16'h0102); put_word(16'h0304);
        drain("rst_mid");
        check("rst_mid_fd0", fd_cnt[0], 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
